// File: rtl/cadre_pkg.sv
// Shared definitions for the animated border block.
//   - side codes used by cotes_en bit positions and impact_cote
//   - FSM state encoding (REPOS / FLASH)
//   - default colour constants (5-bit palette indices)
package cadre_pkg;

  localparam logic [1:0] COTE_GAUCHE = 2'd0;
  localparam logic [1:0] COTE_DROITE = 2'd1;
  localparam logic [1:0] COTE_HAUT   = 2'd2;
  localparam logic [1:0] COTE_BAS    = 2'd3;

  typedef enum logic {
    REPOS = 1'b0,
    FLASH = 1'b1
  } etat_t;

  localparam logic [4:0] COUL_CADRE_DEF = 5'd20;
  localparam logic [4:0] COUL_FLASH_DEF = 5'd31;
  localparam logic [4:0] COUL_FOND_DEF  = 5'd0;

endpackage

// File: rtl/cadre_flash_fsm.sv
// Flash sequencer for the animated border.
// An impact latches the side hit and loads a frame down-counter; each frame
// tick decrements it until the flash ends. A new impact restarts the flash
// and wins over a simultaneous tick.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   tick         : frame tick (one cycle per frame)
//   impact       : single-cycle impact pulse
//   impact_cote  : side hit, sampled only with impact
//   flash_actif  : state == FLASH (registered)
//   cote_f       : latched flashing side
//   cpt          : remaining flash frames
module cadre_flash_fsm
  import cadre_pkg::*;
#(
  parameter int unsigned FLASH_TRAMES = 8,
  parameter int unsigned CW           = $clog2(FLASH_TRAMES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          impact,
  input  logic [1:0]    impact_cote,
  output logic          flash_actif,
  output logic [1:0]    cote_f,
  output logic [CW-1:0] cpt
);

  localparam logic [CW-1:0] CPT_PLEIN = CW'(FLASH_TRAMES);
  localparam logic [CW-1:0] CPT_UN    = CW'(1);

  etat_t         state, state_n;
  logic [1:0]    cote_n;
  logic [CW-1:0] cpt_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= REPOS;
      cote_f <= '0;
      cpt    <= '0;
    end else begin
      state  <= state_n;
      cote_f <= cote_n;
      cpt    <= cpt_n;
    end
  end

  always_comb begin
    state_n = state;
    cote_n  = cote_f;
    cpt_n   = cpt;
    case (state)
      REPOS: begin
        if (impact) begin
          state_n = FLASH;
          cote_n  = impact_cote;
          cpt_n   = CPT_PLEIN;
        end
      end
      FLASH: begin
        // Impact checked first so a coincident tick cannot eat a frame.
        if (impact) begin
          cote_n = impact_cote;
          cpt_n  = CPT_PLEIN;
        end else if (tick) begin
          if (cpt == CPT_UN) begin
            state_n = REPOS;
            cpt_n   = '0;
          end else begin
            cpt_n = cpt - CPT_UN;
          end
        end
      end
      default: state_n = REPOS;
    endcase
  end

  assign flash_actif = (state == FLASH);

endmodule

// File: rtl/cadre_anime.sv
// Animated screen border: draws enabled sides in a steady colour and blinks
// the last side hit by the ball for a few frames.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   hpos, vpos   : current pixel column / line
//   cotes_en     : side enables (0 left, 1 right, 2 top, 3 bottom)
//   impact       : single-cycle pulse when the ball hits a side
//   impact_cote  : side hit, sampled only with impact
//   couleur      : registered pixel colour (1-cycle latency)
//   flash_actif  : high while the flash is running
module cadre_anime
  import cadre_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned EPAIS        = 3,
  parameter logic [4:0]  COUL_CADRE   = COUL_CADRE_DEF,
  parameter logic [4:0]  COUL_FLASH   = COUL_FLASH_DEF,
  parameter logic [4:0]  COUL_FOND    = COUL_FOND_DEF,
  parameter int unsigned FLASH_TRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hpos,
  input  logic [10:0] vpos,
  input  logic [3:0]  cotes_en,
  input  logic        impact,
  input  logic [1:0]  impact_cote,
  output logic [4:0]  couleur,
  output logic        flash_actif
);

  localparam int unsigned CW = $clog2(FLASH_TRAMES + 1);

  localparam logic [10:0] H_MAX   = 11'(H_ACTIVE);
  localparam logic [10:0] V_MAX   = 11'(V_ACTIVE);
  localparam logic [10:0] EP      = 11'(EPAIS);
  localparam logic [10:0] H_DROIT = 11'(H_ACTIVE - EPAIS);
  localparam logic [10:0] V_BAS   = 11'(V_ACTIVE - EPAIS);

  logic          tick;
  logic          hors_zone;
  logic [3:0]    sur_cote;
  logic [3:0]    cote_actif;
  logic          flash_pix;
  logic          en_flash;
  logic [1:0]    cote_f;
  logic [CW-1:0] cpt;
  logic [4:0]    couleur_n;

  assign tick = (hpos == '0) && (vpos == '0);

  cadre_flash_fsm #(
    .FLASH_TRAMES(FLASH_TRAMES),
    .CW          (CW)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .impact     (impact),
    .impact_cote(impact_cote),
    .flash_actif(en_flash),
    .cote_f     (cote_f),
    .cpt        (cpt)
  );

  assign flash_actif = en_flash;

  always_comb begin
    hors_zone = (hpos >= H_MAX) || (vpos >= V_MAX);

    sur_cote              = '0;
    sur_cote[COTE_GAUCHE] = hpos < EP;
    sur_cote[COTE_DROITE] = (hpos >= H_DROIT) && (hpos < H_MAX);
    sur_cote[COTE_HAUT]   = vpos < EP;
    sur_cote[COTE_BAS]    = (vpos >= V_BAS) && (vpos < V_MAX);

    cote_actif = sur_cote & cotes_en;
    // A disabled flashing side never lights because cote_actif masks it.
    flash_pix  = en_flash && cote_actif[cote_f];

    if (hors_zone) begin
      couleur_n = COUL_FOND;
    end else if (flash_pix) begin
      couleur_n = cpt[0] ? COUL_FLASH : COUL_CADRE;
    end else if (|cote_actif) begin
      couleur_n = COUL_CADRE;
    end else begin
      couleur_n = COUL_FOND;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      couleur <= '0;
    end else begin
      couleur <= couleur_n;
    end
  end

endmodule
